// File: rtl/freq_synth.sv
// freq_synth: note-driven square-wave tone generator for a 50 MHz clock.
module freq_synth (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] note,
    output logic       vib,
    output logic       osc_test,
    output logic [7:0] div_test,
    output logic       bfoct_test
);
    logic [13:0] period;
    logic [13:0] count;
    logic [13:0] base;
    logic [4:0]  note_q;
    logic        active;
    logic        strobe;
    always_comb begin
        period = 14'd0;
        case (note[3:0])
            4'd0:    period = 14'd11944;
            4'd1:    period = 14'd11274;
            4'd2:    period = 14'd10642;
            4'd3:    period = 14'd10044;
            4'd4:    period = 14'd9480;
            4'd5:    period = 14'd8948;
            4'd6:    period = 14'd8446;
            4'd7:    period = 14'd7972;
            4'd8:    period = 14'd7525;
            4'd9:    period = 14'd7102;
            4'd10:   period = 14'd6704;
            4'd11:   period = 14'd6327;
            default: period = 14'd0;
        endcase
    end
    assign active = note[7] && (note[3:0] <= 4'd11);
    // A semitone/enable change restarts the prescaler; the change edge itself is the first count.
    assign base   = ({note[7], note[3:0]} != note_q) ? 14'd0 : count;
    assign strobe = base == (period - 14'd1);
    assign vib    = active && div_test[3'd7 - note[6:4]];
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            count      <= 14'd0;
            osc_test   <= 1'b0;
            div_test   <= 8'd0;
            bfoct_test <= 1'b0;
            note_q     <= 5'd0;
        end else begin
            note_q     <= {note[7], note[3:0]};
            count      <= (!active || strobe) ? 14'd0 : base + 14'd1;
            osc_test   <= active && strobe;
            div_test   <= active ? div_test + {7'd0, strobe} : 8'd0;
            bfoct_test <= active && (bfoct_test ^ strobe);
        end
    end
endmodule

// File: tb/tb_freq_synth.sv
// tb_freq_synth: directed checks of prescaler periods, octave taps, rest and async reset.
module tb_freq_synth;
    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] note = 8'hA7;
    logic       vib;
    logic       osc_test;
    logic [7:0] div_test;
    logic       bfoct_test;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n;

    typedef struct {
        logic [7:0] note;
        int         p;
        logic       vib;
    } vec_t;
    vec_t tbl [3];

    freq_synth dut (
        .clk(clk),
        .reset_n(reset_n),
        .note(note),
        .vib(vib),
        .osc_test(osc_test),
        .div_test(div_test),
        .bfoct_test(bfoct_test)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_strobe(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!osc_test && cnt < 20000);
    endtask

    task automatic to_note(input logic [7:0] v);
        @(negedge clk);
        note = v;
    endtask

    task automatic edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0] = '{8'hC9, 7102, 1'b0};
        tbl[1] = '{8'hFA, 6704, 1'b1};
        tbl[2] = '{8'h86, 8446, 1'b0};

        #12;
        check("reset_vib", vib, 0);
        check("reset_osc", osc_test, 0);
        check("reset_div", div_test, 0);
        check("reset_bfoct", bfoct_test, 0);
        #3 reset_n = 1'b0;

        wait_strobe(n);
        check("g2_first_strobe", n, 7972);
        check("g2_div", div_test, 1);
        check("g2_bfoct", bfoct_test, 1);
        check("g2_vib", vib, 0);

        for (int i = 0; i < 3; i++) begin
            to_note(8'h00);
            edges(1);
            to_note(tbl[i].note);
            wait_strobe(n);
            check("tbl_period", n, tbl[i].p);
            check("tbl_div", div_test, 1);
            check("tbl_bfoct", bfoct_test, 1);
            check("tbl_vib", vib, tbl[i].vib);
            edges(1);
            check("tbl_osc_one_cycle", osc_test, 0);
        end

        to_note(8'h00);
        edges(1);
        to_note(8'hF0);
        wait_strobe(n);
        check("c7_half1", n, 11944);
        check("c7_vib_high", vib, 1);
        wait_strobe(n);
        check("c7_half2", n, 11944);
        check("c7_vib_low", vib, 0);
        check("c7_div", div_test, 2);
        check("c7_bfoct", bfoct_test, 0);

        to_note(8'h00);
        edges(1);
        to_note(8'hFB);
        wait_strobe(n);
        check("b7_period", n, 6327);
        check("b7_vib", vib, 1);
        edges(100);
        to_note(8'hBB);
        #1;
        check("oct_switch_vib", vib, 0);
        wait_strobe(n);
        check("oct_switch_continue", n, 6227);
        check("oct_switch_div", div_test, 2);
        check("oct_switch_bfoct", bfoct_test, 0);

        edges(50);
        #4 reset_n = 1'b1;
        #1;
        check("areset_vib", vib, 0);
        check("areset_osc", osc_test, 0);
        check("areset_div", div_test, 0);
        check("areset_bfoct", bfoct_test, 0);
        #4 reset_n = 1'b0;
        wait_strobe(n);
        check("areset_restart", n, 6327);
        check("areset_div_after", div_test, 1);

        to_note(8'hFB);
        #1;
        check("oct7_tap_vib", vib, 1);
        to_note(8'h7B);
        #1;
        check("rest_vib_now", vib, 0);
        edges(1);
        check("rest_div", div_test, 0);
        check("rest_bfoct", bfoct_test, 0);
        check("rest_osc", osc_test, 0);

        to_note(8'h8C);
        edges(3);
        check("sem12_vib", vib, 0);
        check("sem12_osc", osc_test, 0);
        check("sem12_div", div_test, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/freq_synth.md
FREQ_SYNTH -- requirements
Module: freq_synth

Interface
REQ-001 Parameters: none; the divisor table is fixed for a 50 MHz clk.
REQ-002 clk  input  1  system clock, rising-edge active, 50 MHz.
REQ-003 reset_n  input  1  asynchronous, active-high reset (asserted when 1, despite the name).
REQ-004 note  input  8  note code: [7]=play enable, [6:4]=octave 0..7, [3:0]=semitone (0=C … 11=B, 12..15=rest).
REQ-005 vib  output  1  square-wave tone output.
REQ-006 osc_test  output  1  one-cycle strobe from the semitone prescaler.
REQ-007 div_test  output  8  octave divider counter value.
REQ-008 bfoct_test  output  1  square wave toggling on every osc strobe, before octave division.

Function
REQ-009 The block SHALL decode the prescaler period P[s] from note[3:0] as follows: C 11944, C# 11274, D 10642, D# 10044, E 9480, F 8948, F# 8446, G 7972, G# 7525, A 7102, A# 6704, B 6327.
- These periods give P = round(3125000 / f_oct4), using A4 = 440 Hz equal temperament.
REQ-010 The block SHALL be active when note[7]=1 and note[3:0]<=11; otherwise it is in rest.
REQ-011 The prescaler SHALL be a 14-bit counter, incrementing each clk edge while active, counting 0..P-1.
REQ-012 On the edge where count==P-1, the block SHALL perform all of the following on that same edge:
- count<=0
- osc_test<=1
- div_test<=div_test+1 (8-bit, wraps 255->0)
- bfoct_test<=~bfoct_test
REQ-013 osc_test SHALL be 0 on all other edges, so it is high for exactly 1 cycle per P cycles.
REQ-014 vib SHALL equal div_test[7-octave] when active and 0 in rest (combinational from the div_test register).
- Resulting frequency: 50e6 / (P * 2^(8-octave)).
- Octave 4 SHALL be the concert octave (A4 note=0xC9 gives 440.0 Hz ±0.01%).
REQ-015 The block SHALL keep a registered copy of note[3:0] and note[7].
- If either changes, count SHALL be cleared to 0 on the next edge.
- div_test and bfoct_test SHALL keep their values.
REQ-016 An octave-only change SHALL NOT clear any counter; vib SHALL switch tap immediately.
REQ-017 In rest, the block SHALL:
- hold count=0
- hold osc_test=0
- clear div_test to 0 and bfoct_test to 0 on the next edge
- drive vib=0
REQ-018 Leaving rest SHALL restart from count=0; the first strobe occurs P edges later.
REQ-019 P is at most 11944, so the prescaler SHALL fit in 14 bits; comparisons SHALL be unsigned.

Reset
REQ-020 While reset_n=1, the block SHALL asynchronously force all of the following to 0 and hold them there:
- count
- osc_test
- div_test
- bfoct_test
- the registered note copy
REQ-021 After reset_n deasserts, operation SHALL begin at the first rising clk edge.
- Reset mid-tone SHALL abort immediately, with no partial-cycle glitch on vib beyond the reset assertion.
REQ-022 The registered note copy SHALL be 0 after reset, so a non-rest note at release SHALL count as a change.
- count is already 0, so the timing is identical either way.

Verification
REQ-023 note=0xA7 (G, octave 2), reset released at 15 ns, 20 ns clk period, expected response:
- first osc_test pulse occurs at the 7972nd edge after release
- bfoct_test period = 15944 cycles
- vib first rises after 32*7972 = 255104 edges
- vib period = 510208 cycles (98.0 Hz)
REQ-024 note=0xC9 (A4), expected response:
- osc_test every 7102 cycles
- vib period = 113632 cycles
- div_test wraps 255->0 after 256 strobes
REQ-025 note=0xF0 (C, octave 7): vib SHALL toggle on every strobe, giving a period of 23888 cycles.
REQ-026 Switch note from 0xA7 to 0x27 (enable off) mid-tone:
- vib=0 immediately
- osc_test stays 0
- div_test=0 and bfoct_test=0 one edge later
REQ-027 Switch 0xA7 to 0xC7 (octave change only): count and div_test SHALL continue, and vib SHALL switch to div_test[3].
REQ-028 Assert reset_n=1 for 5 ns between clk edges mid-tone:
- all outputs go 0 asynchronously
- after release, the first strobe occurs P edges later
